// File: rtl/fsmd_loop_counter.sv
// fsmd_loop_counter: bounded up/down loop counter with pause, abort and a
// one-cycle completion pulse. The count is clamped to its target on the final
// step, so it never wraps.
//
// Parameters:
//   WIDTH  counter and limit width in bits (2..16)
//   STEP   per-cycle increment/decrement magnitude (1..2^WIDTH-1)
//
// Ports:
//   CLK    clock, all state updates on its rising edge
//   RST    asynchronous active-high reset
//   START  begin a count (sampled in IDLE only)
//   LIMIT  terminal value, latched with START
//   DIR    0 = count 0 -> LIMIT, 1 = count LIMIT -> 0, latched with START
//   PAUSE  freeze the count while high
//   ABORT  cancel an active count (wins over PAUSE)
//   CNT    registered current count
//   BUSY   registered, high in RUN and HOLD
//   DONE   registered, one-cycle completion pulse
module fsmd_loop_counter #(
   parameter int unsigned WIDTH = 4,
   parameter int unsigned STEP  = 1
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             START,
   input  logic [WIDTH-1:0] LIMIT,
   input  logic             DIR,
   input  logic             PAUSE,
   input  logic             ABORT,
   output logic [WIDTH-1:0] CNT,
   output logic             BUSY,
   output logic             DONE
);

   // One extra bit so the up-count sum cannot wrap before the compare.
   localparam logic [WIDTH:0] StepExt = (WIDTH+1)'(STEP);

   typedef enum logic [1:0] {StIdle, StRun, StHold, StDone} state_e;

   state_e           state_q, state_d;
   logic [WIDTH-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0] limit_q, limit_d;
   logic             dir_q, dir_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic [WIDTH:0]   sum_up;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      limit_d = limit_q;
      dir_d   = dir_q;
      sum_up  = {1'b0, cnt_q} + StepExt;

      case (state_q)
         StIdle: begin
            if (START) begin
               limit_d = LIMIT;
               dir_d   = DIR;
               cnt_d   = DIR ? LIMIT : '0;
               // Start value equals target in both directions exactly when LIMIT is 0.
               state_d = (LIMIT == '0) ? StDone : StRun;
            end
         end
         StRun: begin
            if (ABORT) begin
               state_d = StIdle;
            end else if (PAUSE) begin
               state_d = StHold;
            end else if (!dir_q) begin
               if (sum_up >= {1'b0, limit_q}) begin
                  cnt_d   = limit_q;
                  state_d = StDone;
               end else begin
                  cnt_d = sum_up[WIDTH-1:0];
               end
            end else begin
               if ({1'b0, cnt_q} <= StepExt) begin
                  cnt_d   = '0;
                  state_d = StDone;
               end else begin
                  // cnt_q > STEP here, so STEP fits in WIDTH bits.
                  cnt_d = cnt_q - StepExt[WIDTH-1:0];
               end
            end
         end
         StHold: begin
            if (ABORT) begin
               state_d = StIdle;
            end else if (!PAUSE) begin
               state_d = StRun;
            end
         end
         StDone: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase

      // Outputs are registered from the next state so they are glitch-free.
      busy_d = (state_d == StRun) || (state_d == StHold);
      done_d = (state_d == StDone);
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q <= StIdle;
         cnt_q   <= '0;
         limit_q <= '0;
         dir_q   <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         limit_q <= limit_d;
         dir_q   <= dir_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign CNT  = cnt_q;
   assign BUSY = busy_q;
   assign DONE = done_q;

endmodule
